// File: rtl/ch_mute_seq_if.sv
// Channel sequencer bundle: receiver lock/rate, CSR volume and sample strobes in,
// per-channel reset, effective volume and state readback out.
interface ch_mute_seq_if #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned NUM_RATE  = 5,
  parameter int unsigned VOL_WIDTH = 32
);
  logic [NUM_CH-1:0]           locked_i;
  logic [NUM_CH*NUM_RATE-1:0]  rate_i;
  logic [NUM_CH*VOL_WIDTH-1:0] vol_i;
  logic [NUM_CH-1:0]           tick_i;
  logic [NUM_CH-1:0]           rst_ch_o;
  logic [NUM_CH*VOL_WIDTH-1:0] vol_o;
  logic [NUM_CH*3-1:0]         state_o;

  modport master (
    output locked_i, rate_i, vol_i, tick_i,
    input  rst_ch_o, vol_o, state_o
  );

  modport slave (
    input  locked_i, rate_i, vol_i, tick_i,
    output rst_ch_o, vol_o, state_o
  );
endinterface

// File: rtl/ch_mute_seq.sv
// Per-channel start-up/shut-down sequencer: holds a channel in reset until locked,
// settles, ramps volume up to the CSR target and fades it out on a rate change.
module ch_mute_seq #(
  parameter int unsigned           NUM_CH        = 2,
  parameter int unsigned           NUM_RATE      = 5,
  parameter int unsigned           VOL_WIDTH     = 32,
  parameter int unsigned           SETTLE_CYCLES = 65536,
  parameter logic [VOL_WIDTH-1:0]  RAMP_STEP     = VOL_WIDTH'(32'h0008_0000)
) (
  input  logic          clk,
  input  logic          rst,
  ch_mute_seq_if.slave  bus
);

  localparam int unsigned    CW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_RAMP   = 3'd2,
    S_RUN    = 3'd3,
    S_FADE   = 3'd4
  } state_t;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t               st_q, st_d;
    logic [NUM_RATE-1:0]  rate_q, rate_d, rate;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [VOL_WIDTH-1:0] vol_q, vol_d, tgt;
    logic [VOL_WIDTH:0]   nxt;
    logic                 rst_q, locked, tick;

    assign locked = bus.locked_i[g];
    assign tick   = bus.tick_i[g];
    assign rate   = bus.rate_i[g*NUM_RATE +: NUM_RATE];
    assign tgt    = bus.vol_i[g*VOL_WIDTH +: VOL_WIDTH];
    // One extra bit so the ramp increment can be compared without wrapping.
    assign nxt    = {1'b0, vol_q} + {1'b0, RAMP_STEP};

    always_ff @(posedge clk) begin
      if (rst) begin
        st_q   <= S_IDLE;
        rate_q <= '0;
        cnt_q  <= '0;
        vol_q  <= '0;
        rst_q  <= 1'b1;
      end else begin
        st_q   <= st_d;
        rate_q <= rate_d;
        cnt_q  <= cnt_d;
        vol_q  <= vol_d;
        rst_q  <= (st_d == S_IDLE);
      end
    end

    always_comb begin
      st_d   = st_q;
      rate_d = rate_q;
      cnt_d  = cnt_q;
      vol_d  = vol_q;
      unique case (st_q)
        S_IDLE: begin
          vol_d = '0;
          if (locked && (rate != '0)) begin
            st_d   = S_SETTLE;
            rate_d = rate;
            cnt_d  = '0;
          end
        end
        S_SETTLE: begin
          vol_d = '0;
          cnt_d = cnt_q + CW'(1);
          if (!locked || (rate != rate_q)) st_d = S_IDLE;
          else if (cnt_q == SETTLE_LAST)   st_d = S_RAMP;
        end
        S_RAMP: begin
          if (!locked) begin
            st_d  = S_IDLE;
            vol_d = '0;
          end else if (rate != rate_q) begin
            st_d = S_FADE;
          end else if (tick) begin
            if (nxt >= {1'b0, tgt}) begin
              vol_d = tgt;
              st_d  = S_RUN;
            end else begin
              vol_d = nxt[VOL_WIDTH-1:0];
            end
          end else if (tgt <= vol_q) begin
            vol_d = tgt;
            st_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked) begin
            st_d  = S_IDLE;
            vol_d = '0;
          end else if (rate != rate_q) begin
            st_d = S_FADE;
          end else begin
            vol_d = tgt;
          end
        end
        S_FADE: begin
          // Rate changes are ignored here; the fade completes and IDLE re-latches.
          if (!locked) begin
            st_d  = S_IDLE;
            vol_d = '0;
          end else if (tick) begin
            if (vol_q <= RAMP_STEP) begin
              vol_d = '0;
              st_d  = S_IDLE;
            end else begin
              vol_d = vol_q - RAMP_STEP;
            end
          end
        end
        default: begin
          st_d  = S_IDLE;
          vol_d = '0;
        end
      endcase
    end

    assign bus.rst_ch_o[g]                    = rst_q;
    assign bus.vol_o[g*VOL_WIDTH +: VOL_WIDTH] = vol_q;
    assign bus.state_o[g*3 +: 3]              = st_q;
  end

endmodule

// File: doc/ch_mute_seq.md
# ch_mute_seq

Per-channel start-up/shut-down sequencer between the S/PDIF receivers plus CSR block and the resampler plus mixer in `dmix_top`. It replaces the direct `rst_ch = ~locked` and `vol = csr vol` wiring. It holds a channel in reset until its receiver is locked at a known rate, then waits a settle period. It then soft-ramps that channel's mixer volume up to the CSR target. On a rate change it fades the volume to zero before re-resetting the channel, so the DAC output never clicks.

## Interface
Parameters:
- NUM_CH, 2, number of mixer input channels.
- NUM_RATE, 5, width of one rate code; code 0 means unknown/no rate.
- VOL_WIDTH, 32, unsigned volume word width.
- SETTLE_CYCLES, 65536, clk cycles a channel spends in SETTLE; must be ≥ 1; counter width is $clog2(SETTLE_CYCLES).
- RAMP_STEP, 32'h0008_0000, volume increment/decrement per sample tick; width is VOL_WIDTH.

Ports:
- clk  in  1  mixer/resampler clock (clk491520 in dmix_top).
- rst  in  1  synchronous, active-high reset.
- locked_i  in  NUM_CH  per-channel receiver lock; already synchronous to clk.
- rate_i  in  NUM_CH*NUM_RATE  per-channel rate code; channel n occupies [n*NUM_RATE +: NUM_RATE].
- vol_i  in  NUM_CH*VOL_WIDTH  CSR target volume per channel.
- tick_i  in  NUM_CH  per-channel sample strobe (resampler ack_o); one pulse per output sample.
- rst_ch_o  out  NUM_CH  per-channel reset to the resampler and mixer.
- vol_o  out  NUM_CH*VOL_WIDTH  effective volume to the mixer.
- state_o  out  NUM_CH*3  per-channel state code, for CSR readback.

## Operation
- Channels are fully independent, with one FSM, one rate latch, one settle counter and one volume register each. Below, "locked", "rate", "tgt" and "tick" are channel n's slices.
- States (code): IDLE=0, SETTLE=1, RAMP=2, RUN=3, FADE=4.
- IDLE: rst_ch_o=1, vol_o=0.
  - If locked && rate!=0, go to SETTLE.
  - On that transition, latch rate into rate_q and clear the counter.
- SETTLE: rst_ch_o=0, vol_o=0. The counter increments every cycle.
  - !locked, or rate!=rate_q: go to IDLE.
  - Else if counter==SETTLE_CYCLES-1: go to RAMP.
- RAMP: rst_ch_o=0.
  - On each tick, compute nxt = vol_o+RAMP_STEP in VOL_WIDTH+1 bits.
  - If nxt ≥ tgt: vol_o=tgt and go to RUN. Otherwise vol_o=nxt.
  - Without a tick, if tgt ≤ vol_o (the CSR lowered the target mid-ramp): vol_o=tgt and go to RUN.
- RUN: rst_ch_o=0, vol_o=tgt. The target passes through with one cycle of register latency.
- FADE: rst_ch_o=0.
  - On each tick, if vol_o ≤ RAMP_STEP: vol_o=0 and go to IDLE. Otherwise vol_o -= RAMP_STEP.
- Priority, highest first:
  1. rst.
  2. !locked in any non-IDLE state: go to IDLE the next cycle. There is no fade, because there is no data to fade.
  3. rate!=rate_q in RAMP or RUN: go to FADE.
  4. The normal transitions above.
- A rate change during FADE is ignored; the channel completes the fade and then re-enters via IDLE.
- In IDLE, if tgt=0 the channel still sequences normally: RAMP exits on the first cycle with vol_o=0.
- The volume never wraps. Addition saturates at tgt, and subtraction floors at 0.

## Timing
- All outputs are registered. Reset values: rst_ch_o=all 1, vol_o=0, state_o=0 (all IDLE).
- Each state change is visible on state_o, and its effect on rst_ch_o and vol_o is visible, one clk after the cycle in which the condition is sampled.
- locked falls at cycle t: rst_ch_o=1 and vol_o=0 at t+1, regardless of state.
- Rate acquisition: rst_ch_o falls one cycle after locked && rate!=0 is seen in IDLE. RAMP is entered SETTLE_CYCLES cycles later.
- Ramp length: ceil(tgt/RAMP_STEP) ticks. Fade length: ceil(vol_o/RAMP_STEP) ticks.
- A tick arriving in the same cycle as an exit condition is ignored; the exit wins.
- rst asserted mid-operation returns every channel to its reset values on the next edge, whatever its state or volume.

## Test plan
Bench parameters: NUM_CH=2, SETTLE_CYCLES=8, RAMP_STEP=32'h1000_0000.
- Reset with locked=0: rst_ch_o=2'b11, vol_o=0, state_o=0 for every cycle.
- ch0: locked=1, rate=3, tgt=32'h3000_0000, tick every 4 cycles.
  - rst_ch_o[0] falls at +1, and state becomes RAMP at +9.
  - vol_o steps 0x1000_0000, 0x2000_0000, 0x3000_0000, then RUN.
  - ch1 stays IDLE throughout.
- ch0 in RUN at 0x3000_0000, rate changes from 3 to 4: FADE, with vol steps 0x2000_0000, 0x1000_0000, 0. Then IDLE with rst_ch_o[0]=1, then re-sequences at rate 4.
- ch0 in RAMP at 0x1000_0000, locked drops: next cycle rst_ch_o[0]=1, vol=0, state=IDLE.
- ch0 mid-ramp at 0x2000_0000, tgt lowered to 0x1800_0000 with no tick: next cycle vol=0x1800_0000, RUN. A later tgt change to 0x0 passes through in 1 cycle.
- Both channels mid-ramp, rst pulsed for 1 cycle: all outputs return to their reset values. A tick coinciding with a rate change in RAMP leads to FADE with the volume unchanged.
